// File: rtl/pipeline_hzctl_if.sv
// rtl/pipeline_hzctl_if.sv - pipeline-side signal bundle for the hazard/stall controller
interface pipeline_hzctl_if #(
    parameter int CNTW = 16
);
    logic [4:0]      rs_d;
    logic [4:0]      rt_d;
    logic [4:0]      rs_e;
    logic [4:0]      rt_e;
    logic [4:0]      writereg_e;
    logic [4:0]      writereg_m;
    logic [4:0]      writereg_w;
    logic            regwrite_e;
    logic            regwrite_m;
    logic            regwrite_w;
    logic            memtoreg_e;
    logic            memtoreg_m;
    logic            branch_d;
    logic            jumptoreg_d;
    logic            pcsrc_d;
    logic            imem_ready;
    logic            dmem_req_m;
    logic            dmem_ready;

    logic            stall_f;
    logic            stall_d;
    logic            stall_e;
    logic            stall_m;
    logic            flush_d;
    logic            flush_e;
    logic            flush_w;
    logic            fwda_d;
    logic            fwdb_d;
    logic [1:0]      fwda_e;
    logic [1:0]      fwdb_e;
    logic [CNTW-1:0] cnt_ld;
    logic [CNTW-1:0] cnt_br;
    logic [CNTW-1:0] cnt_mem;
    logic [1:0]      state;

    modport master (
        output rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w,
               regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
               branch_d, jumptoreg_d, pcsrc_d, imem_ready, dmem_req_m, dmem_ready,
        input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
               fwda_d, fwdb_d, fwda_e, fwdb_e, cnt_ld, cnt_br, cnt_mem, state
    );

    modport slave (
        input  rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w,
               regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
               branch_d, jumptoreg_d, pcsrc_d, imem_ready, dmem_req_m, dmem_ready,
        output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_w,
               fwda_d, fwdb_d, fwda_e, fwdb_e, cnt_ld, cnt_br, cnt_mem, state
    );
endinterface

// File: rtl/pipeline_hzctl.sv
// rtl/pipeline_hzctl.sv - 5-stage MIPS hazard, forwarding, memory-wait and stall-statistics controller
module pipeline_hzctl #(
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            reset_n,
    pipeline_hzctl_if.slave hz
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'b00,
        ST_IWAIT = 2'b01,
        ST_DWAIT = 2'b10
    } state_e;

    state_e          state_q, state_d;
    logic [CNTW-1:0] cnt_ld_q, cnt_ld_d;
    logic [CNTW-1:0] cnt_br_q, cnt_br_d;
    logic [CNTW-1:0] cnt_mem_q, cnt_mem_d;

    logic            ld_hz, br_hz, hz_any;
    logic            br_rs, br_rt;
    logic            dmiss, imiss;

    logic            stall_f, stall_d, stall_e, stall_m;
    logic            flush_d, flush_e, flush_w;
    logic            fwda_d, fwdb_d;
    logic [1:0]      fwda_e, fwdb_e;

    // Register $0 is hardwired to zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] a, input logic [4:0] b);
        return (a == b) && (a != 5'd0);
    endfunction

    function automatic logic [1:0] fwd_sel(input logic [4:0] src,
                                           input logic       rw_m,
                                           input logic [4:0] wr_m,
                                           input logic       rw_w,
                                           input logic [4:0] wr_w);
        if (rw_m && reg_match(src, wr_m)) begin
            return 2'b10;
        end else if (rw_w && reg_match(src, wr_w)) begin
            return 2'b01;
        end
        return 2'b00;
    endfunction

    always_comb begin
        ld_hz  = hz.memtoreg_e & hz.regwrite_e &
                 (reg_match(hz.rs_d, hz.writereg_e) | reg_match(hz.rt_d, hz.writereg_e));
        // ID comparator needs the value now: an EX producer is not ready, nor is a MEM load.
        br_rs  = (hz.regwrite_e & reg_match(hz.rs_d, hz.writereg_e)) |
                 (hz.memtoreg_m & reg_match(hz.rs_d, hz.writereg_m));
        br_rt  = (hz.regwrite_e & reg_match(hz.rt_d, hz.writereg_e)) |
                 (hz.memtoreg_m & reg_match(hz.rt_d, hz.writereg_m));
        br_hz  = (hz.branch_d & (br_rs | br_rt)) | (hz.jumptoreg_d & br_rs);
        hz_any = ld_hz | br_hz;
        dmiss  = hz.dmem_req_m & ~hz.dmem_ready;
        imiss  = ~hz.imem_ready;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_RUN: begin
                if (dmiss) begin
                    state_d = ST_DWAIT;
                end else if (imiss) begin
                    state_d = ST_IWAIT;
                end
            end
            ST_IWAIT: begin
                if (dmiss) begin
                    state_d = ST_DWAIT;
                end else if (!imiss) begin
                    state_d = ST_RUN;
                end
            end
            ST_DWAIT: begin
                if (!dmiss) begin
                    state_d = imiss ? ST_IWAIT : ST_RUN;
                end
            end
            default: state_d = ST_RUN;
        endcase
    end

    // Strobes follow the next state so a miss freezes the pipe in the cycle it is seen.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (!reset_n) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
            flush_w = 1'b1;
        end else begin
            case (state_d)
                ST_DWAIT: begin
                    stall_f = 1'b1;
                    stall_d = 1'b1;
                    stall_e = 1'b1;
                    stall_m = 1'b1;
                    flush_w = 1'b1;
                end
                ST_IWAIT: begin
                    stall_f = 1'b1;
                    flush_d = 1'b1;
                    stall_d = hz_any;
                    flush_e = hz_any;
                end
                default: begin
                    stall_f = hz_any;
                    stall_d = hz_any;
                    flush_e = hz_any;
                    flush_d = hz.pcsrc_d & ~hz_any;
                end
            endcase
        end
    end

    always_comb begin
        fwda_d = 1'b0;
        fwdb_d = 1'b0;
        fwda_e = 2'b00;
        fwdb_e = 2'b00;
        if (reset_n) begin
            fwda_d = hz.regwrite_m & reg_match(hz.rs_d, hz.writereg_m);
            fwdb_d = hz.regwrite_m & reg_match(hz.rt_d, hz.writereg_m);
            fwda_e = fwd_sel(hz.rs_e, hz.regwrite_m, hz.writereg_m, hz.regwrite_w, hz.writereg_w);
            fwdb_e = fwd_sel(hz.rt_e, hz.regwrite_m, hz.writereg_m, hz.regwrite_w, hz.writereg_w);
        end
    end

    // One counter per cycle: memory wait outranks load-use, which outranks branch.
    always_comb begin
        cnt_ld_d  = cnt_ld_q;
        cnt_br_d  = cnt_br_q;
        cnt_mem_d = cnt_mem_q;
        if (state_d != ST_RUN) begin
            if (cnt_mem_q != '1) begin
                cnt_mem_d = cnt_mem_q + CNTW'(1);
            end
        end else if (ld_hz) begin
            if (cnt_ld_q != '1) begin
                cnt_ld_d = cnt_ld_q + CNTW'(1);
            end
        end else if (br_hz) begin
            if (cnt_br_q != '1) begin
                cnt_br_d = cnt_br_q + CNTW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_RUN;
            cnt_ld_q  <= '0;
            cnt_br_q  <= '0;
            cnt_mem_q <= '0;
        end else begin
            state_q   <= state_d;
            cnt_ld_q  <= cnt_ld_d;
            cnt_br_q  <= cnt_br_d;
            cnt_mem_q <= cnt_mem_d;
        end
    end

    assign hz.stall_f = stall_f;
    assign hz.stall_d = stall_d;
    assign hz.stall_e = stall_e;
    assign hz.stall_m = stall_m;
    assign hz.flush_d = flush_d;
    assign hz.flush_e = flush_e;
    assign hz.flush_w = flush_w;
    assign hz.fwda_d  = fwda_d;
    assign hz.fwdb_d  = fwdb_d;
    assign hz.fwda_e  = fwda_e;
    assign hz.fwdb_e  = fwdb_e;
    assign hz.cnt_ld  = cnt_ld_q;
    assign hz.cnt_br  = cnt_br_q;
    assign hz.cnt_mem = cnt_mem_q;
    assign hz.state   = state_q;

endmodule

// File: tb/tb_pipeline_hzctl.sv
// tb/tb_pipeline_hzctl.sv - self-checking bench for pipeline_hzctl
module tb_pipeline_hzctl;

    logic clk;
    logic reset_n;
    int   checks;
    int   errors;

    pipeline_hzctl_if #(.CNTW(16)) bus ();

    pipeline_hzctl #(.CNTW(16)) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .hz      (bus.slave)
    );

    always #5 clk = ~clk;

    // {stall_f,stall_d,stall_e,stall_m, flush_d,flush_e,flush_w, fwda_d,fwdb_d, fwda_e, fwdb_e}
    logic [12:0] dut_ctl;
    assign dut_ctl = {bus.stall_f, bus.stall_d, bus.stall_e, bus.stall_m,
                      bus.flush_d, bus.flush_e, bus.flush_w,
                      bus.fwda_d, bus.fwdb_d, bus.fwda_e, bus.fwdb_e};

    logic [1:0] m_state;
    int         m_ld, m_br, m_mem;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        bus.rs_d = 0; bus.rt_d = 0; bus.rs_e = 0; bus.rt_e = 0;
        bus.writereg_e = 0; bus.writereg_m = 0; bus.writereg_w = 0;
        bus.regwrite_e = 0; bus.regwrite_m = 0; bus.regwrite_w = 0;
        bus.memtoreg_e = 0; bus.memtoreg_m = 0;
        bus.branch_d = 0; bus.jumptoreg_d = 0; bus.pcsrc_d = 0;
        bus.imem_ready = 1; bus.dmem_req_m = 0; bus.dmem_ready = 1;
    endtask

    function automatic bit same_reg(input logic [4:0] a, input logic [4:0] b);
        return (a != 0) && (a == b);
    endfunction

    // 0 = running, 1 = waiting on fetch, 2 = frozen on data; every state resolves to this directly.
    function automatic int model_mode();
        if (bus.dmem_req_m && !bus.dmem_ready) return 2;
        if (!bus.imem_ready) return 1;
        return 0;
    endfunction

    function automatic bit model_ld();
        return bus.memtoreg_e && bus.regwrite_e &&
               (same_reg(bus.rs_d, bus.writereg_e) || same_reg(bus.rt_d, bus.writereg_e));
    endfunction

    function automatic bit model_br();
        logic [4:0] srcs[$];
        if (bus.branch_d) srcs = '{bus.rs_d, bus.rt_d};
        else if (bus.jumptoreg_d) srcs = '{bus.rs_d};
        foreach (srcs[k]) begin
            if (bus.regwrite_e && same_reg(srcs[k], bus.writereg_e)) return 1;
            if (bus.memtoreg_m && same_reg(srcs[k], bus.writereg_m)) return 1;
        end
        return 0;
    endfunction

    function automatic logic [1:0] model_fwd(input logic [4:0] src);
        if (bus.regwrite_m && same_reg(src, bus.writereg_m)) return 2'b10;
        if (bus.regwrite_w && same_reg(src, bus.writereg_w)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [12:0] model_ctl();
        int mode;
        bit h;
        mode = model_mode();
        h = model_ld() || model_br();
        return {mode != 0 || h, mode == 2 || h, mode == 2, mode == 2,
                mode == 1 || (mode == 0 && bus.pcsrc_d && !h), mode != 2 && h, mode == 2,
                bus.regwrite_m && same_reg(bus.rs_d, bus.writereg_m),
                bus.regwrite_m && same_reg(bus.rt_d, bus.writereg_m),
                model_fwd(bus.rs_e), model_fwd(bus.rt_e)};
    endfunction

    task automatic test_reset();
        logic [12:0] want;
        set_idle();
        bus.regwrite_m = 1; bus.writereg_m = 1; bus.rs_e = 1; bus.rs_d = 1;
        bus.dmem_req_m = 1; bus.dmem_ready = 0;
        tick();
        want = 13'b0000_111_0_0_00_00;
        checks++;
        if (dut_ctl !== want) begin errors++; $display("FAIL reset_ctl got %b want %b", dut_ctl, want); end
        checks++;
        if ({bus.state, bus.cnt_ld, bus.cnt_br, bus.cnt_mem} !== 50'd0) begin
            errors++; $display("FAIL reset_regs state %b ld %0d br %0d mem %0d want all 0",
                               bus.state, bus.cnt_ld, bus.cnt_br, bus.cnt_mem);
        end
        set_idle();
        reset_n = 1;
        #2;
        checks++;
        if (dut_ctl !== 13'd0 || bus.state !== 2'b00) begin
            errors++; $display("FAIL reset_release ctl %b state %b want 0/00", dut_ctl, bus.state);
        end
        tick();
    endtask

    task automatic test_forwarding();
        logic [12:0] want;
        set_idle();
        bus.regwrite_m = 1; bus.writereg_m = 1; bus.rs_e = 1;
        #2; want = 13'b0000_000_0_0_10_00; checks++;
        if (dut_ctl !== want) begin errors++; $display("FAIL fwd_mem got %b want %b", dut_ctl, want); end
        bus.regwrite_m = 0; bus.regwrite_w = 1; bus.writereg_w = 1;
        #2; want = 13'b0000_000_0_0_01_00; checks++;
        if (dut_ctl !== want) begin errors++; $display("FAIL fwd_wb got %b want %b", dut_ctl, want); end
        bus.regwrite_m = 1; bus.rt_e = 1; bus.rs_d = 1;
        #2; want = 13'b0000_000_1_0_10_10; checks++;
        if (dut_ctl !== want) begin errors++; $display("FAIL fwd_both got %b want %b", dut_ctl, want); end
        bus.writereg_m = 0; bus.writereg_w = 0; bus.rs_e = 0; bus.rt_e = 0; bus.rs_d = 0;
        #2; want = 13'd0; checks++;
        if (dut_ctl !== want) begin errors++; $display("FAIL fwd_zero got %b want %b", dut_ctl, want); end
        tick();
    endtask

    task automatic test_load_use();
        logic [12:0] want;
        set_idle();
        bus.memtoreg_e = 1; bus.regwrite_e = 1; bus.writereg_e = 5; bus.rt_d = 5;
        #2; want = 13'b1100_010_0_0_00_00; checks++;
        if (dut_ctl !== want || bus.cnt_ld !== 16'd0) begin
            errors++; $display("FAIL ldu_stall got %b cnt %0d want %b cnt 0", dut_ctl, bus.cnt_ld, want);
        end
        tick();
        bus.memtoreg_e = 0; bus.regwrite_e = 0; bus.writereg_e = 0;
        bus.memtoreg_m = 1; bus.regwrite_m = 1; bus.writereg_m = 5;
        #2; want = 13'b0000_000_0_1_00_00; checks++;
        if (dut_ctl !== want || bus.cnt_ld !== 16'd1) begin
            errors++; $display("FAIL ldu_bubble got %b cnt %0d want %b cnt 1", dut_ctl, bus.cnt_ld, want);
        end
        tick();
        bus.memtoreg_m = 0; bus.regwrite_m = 0; bus.writereg_m = 0; bus.rt_d = 0;
        bus.rt_e = 5; bus.regwrite_w = 1; bus.writereg_w = 5;
        #2; want = 13'b0000_000_0_0_00_01; checks++;
        if (dut_ctl !== want || bus.cnt_ld !== 16'd1) begin
            errors++; $display("FAIL ldu_wbfwd got %b cnt %0d want %b cnt 1", dut_ctl, bus.cnt_ld, want);
        end
        tick();
    endtask

    task automatic test_branch();
        logic [12:0] want;
        set_idle();
        bus.branch_d = 1; bus.rs_d = 3; bus.regwrite_e = 1; bus.writereg_e = 3; bus.pcsrc_d = 1;
        #2; want = 13'b1100_010_0_0_00_00; checks++;
        if (dut_ctl !== want) begin errors++; $display("FAIL br_alu got %b want %b", dut_ctl, want); end
        tick();
        bus.regwrite_e = 0; bus.writereg_e = 0; bus.regwrite_m = 1; bus.writereg_m = 3;
        #2; want = 13'b0000_100_1_0_00_00; checks++;
        if (dut_ctl !== want || bus.cnt_br !== 16'd1) begin
            errors++; $display("FAIL br_taken got %b cnt %0d want %b cnt 1", dut_ctl, bus.cnt_br, want);
        end
        tick();
        set_idle();
        bus.jumptoreg_d = 1; bus.rs_d = 7; bus.rt_d = 9; bus.regwrite_e = 1; bus.writereg_e = 9;
        #2; checks++;
        if (dut_ctl !== 13'd0) begin errors++; $display("FAIL br_jr_rt got %b want 0", dut_ctl); end
        tick();
        set_idle();
        bus.branch_d = 1; bus.rs_d = 2; bus.rt_d = 4;
        bus.memtoreg_m = 1; bus.regwrite_m = 1; bus.writereg_m = 4;
        #2; want = 13'b1100_010_0_1_00_00; checks++;
        if (dut_ctl !== want || bus.cnt_br !== 16'd1) begin
            errors++; $display("FAIL br_load got %b cnt %0d want %b cnt 1", dut_ctl, bus.cnt_br, want);
        end
        tick();
        checks++;
        if (bus.cnt_br !== 16'd2 || bus.cnt_ld !== 16'd1) begin
            errors++; $display("FAIL br_count br %0d ld %0d want 2/1", bus.cnt_br, bus.cnt_ld);
        end
    endtask

    task automatic test_dwait();
        logic [12:0] want;
        set_idle();
        bus.dmem_req_m = 1; bus.dmem_ready = 0;
        bus.memtoreg_e = 1; bus.regwrite_e = 1; bus.writereg_e = 5; bus.rs_d = 5;
        for (int i = 0; i < 3; i++) begin
            #2; want = 13'b1111_001_0_0_00_00; checks++;
            if (dut_ctl !== want || bus.state !== (i == 0 ? 2'b00 : 2'b10)) begin
                errors++; $display("FAIL dwait_%0d got %b state %b want %b", i, dut_ctl, bus.state, want);
            end
            tick();
        end
        bus.dmem_ready = 1;
        #2; want = 13'b1100_010_0_0_00_00; checks++;
        if (dut_ctl !== want || bus.state !== 2'b10 || bus.cnt_mem !== 16'd3) begin
            errors++; $display("FAIL dwait_exit got %b state %b mem %0d want %b 10 3",
                               dut_ctl, bus.state, bus.cnt_mem, want);
        end
        tick();
        checks++;
        if (bus.state !== 2'b00 || bus.cnt_mem !== 16'd3 || bus.cnt_ld !== 16'd2) begin
            errors++; $display("FAIL dwait_after state %b mem %0d ld %0d want 00 3 2",
                               bus.state, bus.cnt_mem, bus.cnt_ld);
        end
    endtask

    task automatic test_nested();
        logic [1:0]  want_state [4] = '{2'b01, 2'b10, 2'b01, 2'b00};
        logic [12:0] want_ctl   [4] = '{13'b1000_100_0_0_00_00, 13'b1111_001_0_0_00_00,
                                        13'b1000_100_0_0_00_00, 13'd0};
        set_idle();
        for (int i = 0; i < 4; i++) begin
            bus.imem_ready = (i == 3);
            bus.dmem_req_m = (i == 1 || i == 2);
            bus.dmem_ready = (i != 1);
            #2; checks++;
            if (dut_ctl !== want_ctl[i]) begin
                errors++; $display("FAIL nest_ctl_%0d got %b want %b", i, dut_ctl, want_ctl[i]);
            end
            tick();
            checks++;
            if (bus.state !== want_state[i]) begin
                errors++; $display("FAIL nest_state_%0d got %b want %b", i, bus.state, want_state[i]);
            end
        end
        checks++;
        if (bus.cnt_mem !== 16'd6) begin errors++; $display("FAIL nest_cnt got %0d want 6", bus.cnt_mem); end
    endtask

    task automatic test_reset_mid_dwait();
        set_idle();
        bus.dmem_req_m = 1; bus.dmem_ready = 0;
        tick();
        checks++;
        if (bus.state !== 2'b10) begin errors++; $display("FAIL rst_pre state %b want 10", bus.state); end
        #2;
        reset_n = 0;
        #1; checks++;
        if (dut_ctl !== 13'b0000_111_0_0_00_00 || bus.state !== 2'b00 ||
            bus.cnt_ld !== 16'd0 || bus.cnt_br !== 16'd0 || bus.cnt_mem !== 16'd0) begin
            errors++; $display("FAIL rst_async ctl %b state %b ld %0d br %0d mem %0d want 0000111000000 00 0 0 0",
                               dut_ctl, bus.state, bus.cnt_ld, bus.cnt_br, bus.cnt_mem);
        end
        tick();
        checks++;
        if (bus.cnt_mem !== 16'd0 || bus.state !== 2'b00) begin
            errors++; $display("FAIL rst_held mem %0d state %b want 0 00", bus.cnt_mem, bus.state);
        end
        set_idle();
        reset_n = 1;
        tick();
        checks++;
        if (dut_ctl !== 13'd0 || bus.cnt_mem !== 16'd0) begin
            errors++; $display("FAIL rst_exit ctl %b mem %0d want 0 0", dut_ctl, bus.cnt_mem);
        end
    endtask

    task automatic test_saturation();
        set_idle();
        bus.memtoreg_e = 1; bus.regwrite_e = 1; bus.writereg_e = 6; bus.rs_d = 6;
        bus.branch_d = 1;
        repeat (65534) tick();
        checks++;
        if (bus.cnt_ld !== 16'd65534) begin errors++; $display("FAIL sat_pre got %0d want 65534", bus.cnt_ld); end
        repeat (3) tick();
        checks++;
        if (bus.cnt_ld !== 16'd65535 || bus.cnt_br !== 16'd0 || bus.cnt_mem !== 16'd0) begin
            errors++; $display("FAIL sat_hold ld %0d br %0d mem %0d want 65535 0 0",
                               bus.cnt_ld, bus.cnt_br, bus.cnt_mem);
        end
    endtask

    task automatic test_random();
        int mode;
        reset_n = 0;
        set_idle();
        tick();
        reset_n = 1;
        m_state = 2'b00; m_ld = 0; m_br = 0; m_mem = 0;
        for (int i = 0; i < 600; i++) begin
            bus.rs_d = 5'($urandom_range(0, 3));       bus.rt_d = 5'($urandom_range(0, 3));
            bus.rs_e = 5'($urandom_range(0, 3));       bus.rt_e = 5'($urandom_range(0, 3));
            bus.writereg_e = 5'($urandom_range(0, 3)); bus.writereg_m = 5'($urandom_range(0, 3));
            bus.writereg_w = 5'($urandom_range(0, 3));
            bus.regwrite_e = 1'($urandom_range(0, 1)); bus.regwrite_m = 1'($urandom_range(0, 1));
            bus.regwrite_w = 1'($urandom_range(0, 1)); bus.memtoreg_e = 1'($urandom_range(0, 1));
            bus.memtoreg_m = 1'($urandom_range(0, 1)); bus.branch_d = 1'($urandom_range(0, 1));
            bus.jumptoreg_d = 1'($urandom_range(0, 1)); bus.pcsrc_d = 1'($urandom_range(0, 1));
            bus.imem_ready = ($urandom_range(0, 3) != 0);
            bus.dmem_req_m = 1'($urandom_range(0, 1));
            bus.dmem_ready = ($urandom_range(0, 2) != 0);
            #2; checks++;
            if (dut_ctl !== model_ctl()) begin
                errors++; $display("FAIL rnd_ctl_%0d got %b want %b", i, dut_ctl, model_ctl());
            end
            checks++;
            if (bus.state !== m_state || bus.cnt_ld !== 16'(m_ld) ||
                bus.cnt_br !== 16'(m_br) || bus.cnt_mem !== 16'(m_mem)) begin
                errors++; $display("FAIL rnd_regs_%0d state %b ld %0d br %0d mem %0d want %b %0d %0d %0d", i,
                                   bus.state, bus.cnt_ld, bus.cnt_br, bus.cnt_mem, m_state, m_ld, m_br, m_mem);
            end
            mode = model_mode();
            m_state = 2'(mode);
            if (mode != 0) m_mem = (m_mem < 65535) ? m_mem + 1 : m_mem;
            else if (model_ld()) m_ld = (m_ld < 65535) ? m_ld + 1 : m_ld;
            else if (model_br()) m_br = (m_br < 65535) ? m_br + 1 : m_br;
            tick();
        end
    endtask

    initial begin
        clk = 0;
        reset_n = 0;
        checks = 0;
        errors = 0;
        test_reset();
        test_forwarding();
        test_load_use();
        test_branch();
        test_dwait();
        test_nested();
        test_reset_mid_dwait();
        test_saturation();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hzctl.md
# pipeline_hzctl

Hazard and stall controller for the 5-stage MIPS pipeline, with branch/jump resolution in ID. Takes register addresses and control bits from ID/EX/MEM/WB and the instruction/data memory ready handshakes. Produces per-stage stall/flush strobes and forwarding selects for the ID branch comparator and the EX ALU operands. Holds a memory-wait state machine and saturating stall-statistics counters.

## Interface

- CNTW, 16, width of each statistics counter
- clk  in  1  rising-edge clock
- reset_n  in  1  asynchronous, active-low reset
- rs_d, rt_d  in  5 each  source registers of the ID instruction
- rs_e, rt_e  in  5 each  source registers of the EX instruction
- writereg_e, writereg_m, writereg_w  in  5 each  destination register per stage
- regwrite_e, regwrite_m, regwrite_w  in  1 each  stage writes regfile
- memtoreg_e, memtoreg_m  in  1 each  stage instruction is a load
- branch_d, jumptoreg_d  in  1 each  ID instruction is beq/bne, or jr/jalr
- pcsrc_d  in  1  ID redirects the PC
- imem_ready  in  1  fetch data valid this cycle
- dmem_req_m  in  1  MEM stage accesses data memory; stable while frozen
- dmem_ready  in  1  data memory access completes this cycle
- stall_f, stall_d, stall_e, stall_m  out  1 each  hold PC / IF-ID / ID-EX / EX-MEM
- flush_d, flush_e, flush_w  out  1 each  zero IF-ID / ID-EX / MEM-WB (bubble)
- fwda_d, fwdb_d  out  1 each  ID comparator operand from MEM ALU result
- fwda_e, fwdb_e  out  2 each  EX operand: 00 regfile, 01 WB result, 10 MEM result
- cnt_ld, cnt_br, cnt_mem  out  CNTW each  load-use, branch, memory-wait stall cycles
- state  out  2  00 RUN, 01 IWAIT, 10 DWAIT

## Operation

- A match requires a nonzero register number. `match(a, b)` is `a == b && a != 0`.
- Forwarding (combinational):
  - fwda_e = 10 if regwrite_m & match(rs_e, writereg_m); else 01 if regwrite_w & match(rs_e, writereg_w); else 00. fwdb_e is the same using rt_e.
  - fwda_d = regwrite_m & match(rs_d, writereg_m). fwdb_d is the same using rt_d.
- ld_hz = memtoreg_e & regwrite_e & (match(rs_d, writereg_e) | match(rt_d, writereg_e)).
- br_hz asserts when (branch_d | jumptoreg_d) and either:
  - regwrite_e & match(src, writereg_e), or
  - memtoreg_m & match(src, writereg_m).
  - src is rs_d; for branch_d only, rt_d is also checked.
- dmiss = dmem_req_m & ~dmem_ready. imiss = ~imem_ready.
- FSM transitions (dmiss has priority):
  - RUN: dmiss → DWAIT; else imiss → IWAIT; else stay.
  - IWAIT: dmiss → DWAIT; else ~imiss → RUN.
  - DWAIT: ~dmiss → (imiss ? IWAIT : RUN).
- Outputs are decoded from the next-state value (combinational from inputs), so a stall takes effect in the cycle the miss is first seen.
  - next=DWAIT: stall_f, stall_d, stall_e, stall_m = 1; flush_w = 1; all other flushes 0. ld_hz, br_hz and pcsrc_d are ignored.
  - next=IWAIT: stall_f = 1; flush_d = 1; EX/MEM/WB advance. ld_hz/br_hz additionally apply stall_d and flush_e.
  - next=RUN:
    - stall_f = stall_d = ld_hz | br_hz.
    - flush_e = ld_hz | br_hz.
    - flush_d = pcsrc_d & ~(ld_hz | br_hz).
- Counters saturate at all-ones and are updated per clock edge, in priority order:
  - cnt_mem increments when next=DWAIT or next=IWAIT;
  - otherwise cnt_ld increments on ld_hz;
  - otherwise cnt_br increments on br_hz.
  - Only one counter increments per cycle.

## Timing

- Reset (reset_n low, asynchronous): state = RUN, all counters = 0.
  - While reset is held: flush_d = flush_e = flush_w = 1, all stalls 0, all forward selects 0.
- After reset release, the first rising edge evaluates normally.
- Load-use: exactly one bubble. The dependent instruction leaves ID one cycle after the load leaves EX, then uses fwd=01 or the regfile.
- Branch after ALU op: 1 stall cycle. Branch after load: 2 stall cycles.
- DWAIT lasts exactly as many cycles as dmem_ready is low with dmem_req_m high. The pipeline resumes in the cycle dmem_ready=1 is sampled high.
- Simultaneous dmiss and ld_hz: the freeze wins, and ld_hz is re-evaluated on exit because the stages are unchanged.
- Reset mid-DWAIT: state returns to RUN immediately; no counter update on that edge.

## Test plan

- Forwarding: add $1 in MEM (regwrite_m=1, writereg_m=1), rs_e=1 → fwda_e=10. The same in WB only → 01. Both present → 10. writereg=0 with rs_e=0 → 00.
- Load-use: memtoreg_e=1, writereg_e=5, rt_d=5 → stall_f=stall_d=flush_e=1 for one cycle; cnt_ld 0→1.
- Branch resolution, three cases:
  - beq with rs_d=3 behind addi writing $3 (regwrite_e=1) → 1-cycle stall.
  - Next cycle fwda_d=1, pcsrc_d=1 → flush_d=1.
  - jr with rt_d matching but rs_d not matching → no stall.
- Data wait: dmem_req_m=1 with dmem_ready low for 3 cycles → state=10 and all four stalls plus flush_w=1 for 3 cycles; cnt_mem=3; then RUN.
- Nested miss: imem_ready low, then dmem miss arrives → IWAIT→DWAIT→IWAIT (imem still low)→RUN. dmem priority holds.
- Reset: assert reset_n=0 in the middle of DWAIT → state=00, counters 0, flush_d/flush_e/flush_w=1 asynchronously. Saturation check: preload 65534 load-use cycles → cnt_ld stops at 65535.
